mem_tag_remap: RTL and testbench

- Sits directly downstream of the non-cacheable bypass stage, between its memory-side request/response ports and the memory interface.
- Replaces the wide upstream memory tag on reads with a short table index, so the memory system only carries clog2(NUM_ENTRIES) tag bits.
- Stores the original tag in an outstanding-request table and restores it on the matching response.
- Writes pass through untracked; they produce no response.

---
 rtl/mem_tag_remap_pkg.sv | 22 ++
 rtl/VX_priority_encoder.sv | 21 ++
 rtl/mem_tag_remap.sv | 152 +++++++++++++++
 tb/tb_mem_tag_remap.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tag_remap_pkg.sv
// Shared types and helpers for the memory tag remapper.
// Holds the request bundle, the downstream tag width rule and the write tag.
package mem_tag_remap_pkg;

  localparam int REQ_ADDR_W    = 26;
  localparam int REQ_DATA_SIZE = 64;
  localparam int REQ_DATA_W    = REQ_DATA_SIZE * 8;

  localparam int WRITE_TAG_VAL = 0;

  typedef struct packed {
    logic                     rw;
    logic [REQ_ADDR_W-1:0]    addr;
    logic [REQ_DATA_SIZE-1:0] byteen;
    logic [REQ_DATA_W-1:0]    data;
  } mem_req_t;

  function automatic int calc_tag_out_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_priority_encoder.sv
// Lowest-set-bit priority encoder.
// valid_out is low when no input bit is set.
module VX_priority_encoder #(
  parameter int N  = 8,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] index_out,
  output logic          valid_out
);

  always_comb begin
    index_out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (data_in[i]) index_out = LN'(i);
    end
  end

  assign valid_out = |data_in;

endmodule

// File: rtl/mem_tag_remap.sv
// Swaps wide read tags for short table indices, restoring them on response.
// Define MEM_TAG_REMAP_PERF_EN to add full-stall and occupancy counters.
module mem_tag_remap
  import mem_tag_remap_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_DATA_SIZE  = 64,
  parameter int MEM_DATA_WIDTH = MEM_DATA_SIZE * 8,
  parameter int TAG_IN_WIDTH   = 20,
  parameter int NUM_ENTRIES    = 8,
  parameter int TAG_OUT_WIDTH  = calc_tag_out_w(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req_valid_in,
  input  logic                      mem_req_rw_in,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_in,
  input  logic [MEM_DATA_SIZE-1:0]  mem_req_byteen_in,
  input  logic [MEM_DATA_WIDTH-1:0] mem_req_data_in,
  input  logic [TAG_IN_WIDTH-1:0]   mem_req_tag_in,
  output logic                      mem_req_ready_in,
  output logic                      mem_req_valid_out,
  output logic                      mem_req_rw_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_out,
  output logic [MEM_DATA_SIZE-1:0]  mem_req_byteen_out,
  output logic [MEM_DATA_WIDTH-1:0] mem_req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]  mem_req_tag_out,
  input  logic                      mem_req_ready_out,
  input  logic                      mem_rsp_valid_in,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]  mem_rsp_tag_in,
  output logic                      mem_rsp_ready_in,
  output logic                      mem_rsp_valid_out,
  output logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]   mem_rsp_tag_out,
  input  logic                      mem_rsp_ready_out
`ifdef MEM_TAG_REMAP_PERF_EN
  ,
  output logic [43:0]               perf_full_stalls,
  output logic [TAG_OUT_WIDTH:0]    perf_max_pending
`endif
);

  logic [NUM_ENTRIES-1:0]  free_mask;
  logic [NUM_ENTRIES-1:0]  free_next;
  logic [TAG_IN_WIDTH-1:0] tag_table [NUM_ENTRIES];

  logic                      rsp_valid_r;
  logic [MEM_DATA_WIDTH-1:0] rsp_data_r;
  logic [TAG_IN_WIDTH-1:0]   rsp_tag_r;

  logic [TAG_OUT_WIDTH-1:0] alloc_idx;
  logic                     has_free;
  logic                     full;
  logic                     rd_ok;
  logic                     rd_fire;
  logic                     rsp_fire;
  mem_req_t                 req;

  VX_priority_encoder #(
    .N  (NUM_ENTRIES),
    .LN (TAG_OUT_WIDTH)
  ) alloc_enc (
    .data_in   (free_mask),
    .index_out (alloc_idx),
    .valid_out (has_free)
  );

  assign full  = ~has_free;
  assign rd_ok = mem_req_rw_in | ~full;

  assign req = '{
    rw:     mem_req_rw_in,
    addr:   mem_req_addr_in,
    byteen: mem_req_byteen_in,
    data:   mem_req_data_in
  };

  assign mem_req_valid_out  = reset & mem_req_valid_in & rd_ok;
  assign mem_req_ready_in   = mem_req_ready_out & rd_ok;
  assign mem_req_rw_out     = req.rw;
  assign mem_req_addr_out   = req.addr;
  assign mem_req_byteen_out = req.byteen;
  assign mem_req_data_out   = req.data;
  assign mem_req_tag_out    = req.rw ? TAG_OUT_WIDTH'(WRITE_TAG_VAL)
                                     : alloc_idx;

  assign rd_fire  = mem_req_valid_in & mem_req_ready_in & ~mem_req_rw_in;
  assign rsp_fire = mem_rsp_valid_in & mem_rsp_ready_in;

  assign mem_rsp_ready_in  = ~rsp_valid_r | mem_rsp_ready_out;
  assign mem_rsp_valid_out = rsp_valid_r;
  assign mem_rsp_data_out  = rsp_data_r;
  assign mem_rsp_tag_out   = rsp_tag_r;

  // alloc_idx comes from the pre-release mask, so indices never collide
  always_comb begin
    free_next = free_mask;
    if (rsp_fire) free_next[mem_rsp_tag_in] = 1'b1;
    if (rd_fire)  free_next[alloc_idx]      = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      free_mask   <= '1;
      rsp_valid_r <= 1'b0;
    end else begin
      free_mask <= free_next;
      if (rsp_fire)
        rsp_valid_r <= 1'b1;
      else if (mem_rsp_ready_out)
        rsp_valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire)
      tag_table[alloc_idx] <= mem_req_tag_in;
    if (rsp_fire) begin
      rsp_data_r <= mem_rsp_data_in;
      rsp_tag_r  <= tag_table[mem_rsp_tag_in];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && rsp_fire)
      assert (!free_mask[mem_rsp_tag_in])
        else $error("mem_tag_remap: response to free entry %0d",
                    mem_rsp_tag_in);
  end
`endif

`ifdef MEM_TAG_REMAP_PERF_EN
  logic [TAG_OUT_WIDTH:0] pending;

  assign pending = (TAG_OUT_WIDTH + 1)'(NUM_ENTRIES - $countones(free_mask));

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_full_stalls <= '0;
      perf_max_pending <= '0;
    end else begin
      if (mem_req_valid_in & ~mem_req_rw_in & full)
        perf_full_stalls <= perf_full_stalls + 44'd1;
      if (pending > perf_max_pending)
        perf_max_pending <= pending;
    end
  end
`endif

endmodule

// File: tb/tb_mem_tag_remap.sv
// Scoreboard bench for mem_tag_remap: directed scenarios plus random traffic.
// Reference model tracks busy entries and original tags with plain arrays.
module tb_mem_tag_remap;

  localparam int AW = 26;
  localparam int DS = 64;
  localparam int DW = DS * 8;
  localparam int TW = 20;
  localparam int NE = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req_valid_in = 1'b0;
  logic          mem_req_rw_in = 1'b0;
  logic [AW-1:0] mem_req_addr_in = '0;
  logic [DS-1:0] mem_req_byteen_in = '0;
  logic [DW-1:0] mem_req_data_in = '0;
  logic [TW-1:0] mem_req_tag_in = '0;
  logic          mem_req_ready_in;
  logic          mem_req_valid_out;
  logic          mem_req_rw_out;
  logic [AW-1:0] mem_req_addr_out;
  logic [DS-1:0] mem_req_byteen_out;
  logic [DW-1:0] mem_req_data_out;
  logic [OW-1:0] mem_req_tag_out;
  logic          mem_req_ready_out = 1'b1;
  logic          mem_rsp_valid_in = 1'b0;
  logic [DW-1:0] mem_rsp_data_in = '0;
  logic [OW-1:0] mem_rsp_tag_in = '0;
  logic          mem_rsp_ready_in;
  logic          mem_rsp_valid_out;
  logic [DW-1:0] mem_rsp_data_out;
  logic [TW-1:0] mem_rsp_tag_out;
  logic          mem_rsp_ready_out = 1'b1;
`ifdef MEM_TAG_REMAP_PERF_EN
  logic [43:0]   perf_full_stalls;
  logic [OW:0]   perf_max_pending;
`endif

  mem_tag_remap dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid_in   (mem_req_valid_in),
    .mem_req_rw_in      (mem_req_rw_in),
    .mem_req_addr_in    (mem_req_addr_in),
    .mem_req_byteen_in  (mem_req_byteen_in),
    .mem_req_data_in    (mem_req_data_in),
    .mem_req_tag_in     (mem_req_tag_in),
    .mem_req_ready_in   (mem_req_ready_in),
    .mem_req_valid_out  (mem_req_valid_out),
    .mem_req_rw_out     (mem_req_rw_out),
    .mem_req_addr_out   (mem_req_addr_out),
    .mem_req_byteen_out (mem_req_byteen_out),
    .mem_req_data_out   (mem_req_data_out),
    .mem_req_tag_out    (mem_req_tag_out),
    .mem_req_ready_out  (mem_req_ready_out),
    .mem_rsp_valid_in   (mem_rsp_valid_in),
    .mem_rsp_data_in    (mem_rsp_data_in),
    .mem_rsp_tag_in     (mem_rsp_tag_in),
    .mem_rsp_ready_in   (mem_rsp_ready_in),
    .mem_rsp_valid_out  (mem_rsp_valid_out),
    .mem_rsp_data_out   (mem_rsp_data_out),
    .mem_rsp_tag_out    (mem_rsp_tag_out),
    .mem_rsp_ready_out  (mem_rsp_ready_out)
`ifdef MEM_TAG_REMAP_PERF_EN
    ,
    .perf_full_stalls   (perf_full_stalls),
    .perf_max_pending   (perf_max_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  bit            busy [NE];
  logic [TW-1:0] tbl  [NE];
  int            n_checks = 0;
  int            n_errors = 0;
  int            stalls_exp = 0;
  int            max_exp = 0;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int low_free();
    for (int i = 0; i < NE; i++) if (!busy[i]) return i;
    return -1;
  endfunction

  // Upstream response monitor: pops the scoreboard on each accepted output
  always @(negedge clk) begin
    if (reset) begin
      check("rsp_valid_out", mem_rsp_valid_out, sb.size() != 0);
      if (sb.size() != 0 && mem_rsp_valid_out) begin
        check("rsp_tag_out", mem_rsp_tag_out, sb[0].tag);
        check("rsp_data_out", mem_rsp_data_out, sb[0].data);
        if (mem_rsp_ready_out) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle(input bit rv, input bit rw, input logic [TW-1:0] tg,
                       input bit sv, input int si, input logic [DW-1:0] sd,
                       input bit ro, input bit uo);
    int lo;
    int pend;
    bit full;
    bit erdy;
    bit ersp;
    @(posedge clk); #1;
    mem_req_valid_in  = rv;
    mem_req_rw_in     = rw;
    mem_req_tag_in    = tg;
    mem_req_addr_in   = AW'($urandom);
    mem_req_byteen_in = {$urandom, $urandom};
    mem_req_data_in   = rand_line();
    mem_req_ready_out = ro;
    mem_rsp_valid_in  = sv;
    mem_rsp_tag_in    = OW'(si);
    mem_rsp_data_in   = sd;
    mem_rsp_ready_out = uo;
    @(negedge clk); #1;
    lo   = low_free();
    full = (lo < 0);
    erdy = ro && (rw || !full);
    check("req_ready_in", mem_req_ready_in, erdy);
    check("req_valid_out", mem_req_valid_out, rv && (rw || !full));
    if (rv && (rw || !full)) begin
      check("req_tag_out", mem_req_tag_out, rw ? 0 : lo);
      check("req_rw_out", mem_req_rw_out, rw);
      check("req_addr_out", mem_req_addr_out, mem_req_addr_in);
      check("req_byteen_out", mem_req_byteen_out, mem_req_byteen_in);
      check("req_data_out", mem_req_data_out, mem_req_data_in);
    end
    ersp = uo || sb.size() == 0;
    check("rsp_ready_in", mem_rsp_ready_in, ersp);
    if (rv && !rw && full) stalls_exp++;
    if (sv && ersp) begin
      sb.push_back('{tag: tbl[si], data: sd});
      busy[si] = 1'b0;
    end
    if (rv && !rw && erdy) begin
      busy[lo] = 1'b1;
      tbl[lo]  = tg;
    end
    pend = 0;
    for (int i = 0; i < NE; i++) pend += int'(busy[i]);
    if (pend > max_exp) max_exp = pend;
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, '0, 1, 1);
  endtask

  task automatic rd(input logic [TW-1:0] tg);
    cycle(1, 0, tg, 0, 0, '0, 1, 1);
  endtask

  task automatic rsp(input int si, input bit uo);
    cycle(0, 0, '0, 1, si, rand_line(), 1, uo);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset             = 1'b0;
    mem_req_valid_in  = 1'b1;
    mem_req_rw_in     = 1'b0;
    mem_req_ready_out = 1'b1;
    mem_rsp_valid_in  = 1'b0;
    mem_rsp_ready_out = 1'b1;
    sb.delete();
    for (int i = 0; i < NE; i++) busy[i] = 1'b0;
    stalls_exp = 0;
    max_exp    = 0;
    @(negedge clk); #1;
    check("req_valid_out_in_reset", mem_req_valid_out, 1'b0);
    @(posedge clk); #1;
    reset            = 1'b1;
    mem_req_valid_in = 1'b0;
    @(negedge clk); #1;
    check("rsp_valid_after_reset", mem_rsp_valid_out, 1'b0);
  endtask

  initial begin
    int list[$];
    bit rv, rw, sv;
    int si;

    do_reset();
    rd(20'h0ABCD);
    cycle(0, 0, '0, 1, 0, {16{32'hDEADBEEF}}, 1, 1);
    idle();
    rd(20'h00001);

    do_reset();
    for (int i = 0; i < NE; i++) rd(TW'($urandom));
    rd(20'h11111);
    cycle(1, 1, '0, 0, 0, '0, 1, 1);
    cycle(1, 0, 20'h33333, 1, 3, rand_line(), 1, 1);
    rd(20'h33333);

    rsp(5, 1'b0);
    rsp(2, 1'b0);
    rsp(2, 1'b1);
    idle();
    idle();

    do_reset();
    rd(20'h00AAA);
    cycle(1, 0, 20'h00BBB, 1, 0, rand_line(), 1, 1);
    rd(20'h00CCC);
    idle();

    do_reset();
    for (int i = 0; i < 4; i++) rd(TW'($urandom));
    do_reset();
    rd(20'h44444);
    rd(20'h55555);
    idle();

`ifdef MEM_TAG_REMAP_PERF_EN
    do_reset();
    for (int i = 0; i < NE; i++) rd(TW'($urandom));
    for (int i = 0; i < 10; i++) rd(TW'($urandom));
    idle();
    idle();
    check("perf_full_stalls_10", perf_full_stalls, 44'd10);
    check("perf_max_pending_8", perf_max_pending, 8);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      list.delete();
      for (int i = 0; i < NE; i++) if (busy[i]) list.push_back(i);
      rv = $urandom_range(0, 9) < 7;
      rw = $urandom_range(0, 9) < 3;
      sv = list.size() > 0 && $urandom_range(0, 1) == 1;
      si = sv ? list[$urandom_range(0, list.size() - 1)] : 0;
      cycle(rv, rw, TW'($urandom), sv, si, rand_line(),
            $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < NE; i++) if (busy[i]) rsp(i, 1'b1);
    idle();
    idle();
    idle();
`ifdef MEM_TAG_REMAP_PERF_EN
    check("perf_full_stalls", perf_full_stalls, 44'(stalls_exp));
    check("perf_max_pending", perf_max_pending, max_exp);
`endif
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
